// File: rtl/sipo_buf_drain.sv
// Read-out engine for the SIPO capture buffer: issues a programmed number of reads over the
// op/ack/commit handshake and streams each captured word out with a last-word flag.
module sipo_buf_drain #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WORDS   = 64,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_start,
  input  logic [$clog2(WORDS)-1:0]   i_len,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  output logic                       o_buf_val_op,
  output logic                       o_buf_op,
  input  logic                       i_buf_op_ack,
  input  logic                       i_buf_op_commit,
  input  logic [DATA_W-1:0]          i_buf_rdata,
  output logic                       o_out_val,
  input  logic                       i_out_rdy,
  output logic [DATA_W-1:0]          o_out_data,
  output logic                       o_out_last
);

  localparam int unsigned LenW = $clog2(WORDS);
  localparam int unsigned RemW = LenW + 1;
  localparam logic [RemW-1:0] RemFull = RemW'(WORDS);
  localparam logic [3:0] WdogLast = 4'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StOut, StDone} state_t;

  state_t            r_state;
  logic [RemW-1:0]   r_rem;
  logic [3:0]        r_wdog;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_val_op;
  logic              r_out_val;
  logic              r_out_last;
  logic [DATA_W-1:0] r_out_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_rem      <= '0;
      r_wdog     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_val_op   <= 1'b0;
      r_out_val  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_rem    <= (i_len == '0) ? RemFull : {1'b0, i_len};
            r_err    <= 1'b0;
            r_wdog   <= '0;
            r_val_op <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= StReq;
          end
        end
        StReq: begin
          // Expiry wins over a same-cycle ack: the request is abandoned.
          if (r_wdog == WdogLast) begin
            r_err    <= 1'b1;
            r_done   <= 1'b1;
            r_val_op <= 1'b0;
            r_state  <= StDone;
          end else begin
            r_wdog <= r_wdog + 4'd1;
            if (i_buf_op_ack) begin
              r_val_op <= 1'b0;
              r_state  <= StWait;
            end
          end
        end
        StWait: begin
          if (i_buf_op_commit) begin
            r_out_data <= i_buf_rdata;
            r_rem      <= (r_rem != '0) ? r_rem - RemW'(1) : '0;
            r_out_last <= (r_rem == RemW'(1));
            r_out_val  <= 1'b1;
            r_state    <= StOut;
          end else if (r_wdog == WdogLast) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_wdog <= r_wdog + 4'd1;
          end
        end
        StOut: begin
          if (i_out_rdy) begin
            r_out_val  <= 1'b0;
            r_out_last <= 1'b0;
            if (r_rem == '0) begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_wdog   <= '0;
              r_val_op <= 1'b1;
              r_state  <= StReq;
            end
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy   <= 1'b0;
          r_val_op <= 1'b0;
          r_state  <= StIdle;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_buf_val_op = r_val_op;
  assign o_buf_op     = 1'b1;
  assign o_out_val    = r_out_val;
  assign o_out_last   = r_out_last;
  assign o_out_data   = r_out_data;

endmodule

// File: tb/tb_sipo_buf_drain.sv
// Directed bench for sipo_buf_drain: a small buffer model answers reads; each task checks one
// scenario cycle by cycle against hand-derived expectations.
module tb_sipo_buf_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [5:0]  i_len;
  logic        o_busy, o_done, o_err, o_buf_val_op, o_buf_op;
  logic        i_out_rdy;
  logic        o_out_val, o_out_last;
  logic [31:0] o_out_data;

  // Buffer model: acks in the second cycle of a request, commits the cycle after the ack.
  logic        m_ack = 1'b0, m_commit = 1'b0, m_vop_prev = 1'b0;
  logic [31:0] m_rdata = '0, m_base = '0;
  int          m_n = 0, m_limit = 0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sipo_buf_drain dut (
    .clk             (clk),
    .reset           (reset),
    .i_start         (i_start),
    .i_len           (i_len),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_err           (o_err),
    .o_buf_val_op    (o_buf_val_op),
    .o_buf_op        (o_buf_op),
    .i_buf_op_ack    (m_ack),
    .i_buf_op_commit (m_commit),
    .i_buf_rdata     (m_rdata),
    .o_out_val       (o_out_val),
    .i_out_rdy       (i_out_rdy),
    .o_out_data      (o_out_data),
    .o_out_last      (o_out_last)
  );

  always @(posedge clk) begin
    #2;
    if (reset) begin
      m_ack = 1'b0; m_commit = 1'b0; m_vop_prev = 1'b0; m_rdata = '0;
    end else begin
      m_commit = m_ack && (m_n < m_limit);
      if (m_commit) begin
        m_rdata = m_base + 32'(m_n);
        m_n++;
      end
      m_ack = o_buf_val_op && m_vop_prev;
      m_vop_prev = o_buf_val_op;
    end
  end

  // Drives start for the current cycle, which becomes cycle 0 of the scenario.
  task automatic begin_drain(input logic [5:0] len, input logic [31:0] base, input int limit);
    @(posedge clk); #1;
    m_base = base; m_n = 0; m_limit = limit;
    i_len = len; i_start = 1'b1; i_out_rdy = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_start = 1'b1; i_len = 6'd1; i_out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; i_start = 1'b0;
    @(negedge clk);
    total++;
    if ({o_busy, o_done, o_err, o_buf_val_op, o_out_val, o_out_last} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=000000",
                      {o_busy, o_done, o_err, o_buf_val_op, o_out_val, o_out_last});
    end
    total++;
    if (o_buf_op !== 1'b1) begin bad++; $display("FAIL reset_buf_op got=%b want=1", o_buf_op); end
    total++;
    if (o_out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", o_out_data); end
  endtask

  task automatic test_single();
    begin_drain(6'd1, 32'hA5A5_0001, 1);
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      total++;
      if (o_buf_val_op !== (c == 1 || c == 2)) begin
        bad++; $display("FAIL single_vop c=%0d got=%b", c, o_buf_val_op);
      end
      total++;
      if (o_out_val !== (c == 4)) begin bad++; $display("FAIL single_val c=%0d got=%b", c, o_out_val); end
      total++;
      if (o_done !== (c == 5)) begin bad++; $display("FAIL single_done c=%0d got=%b", c, o_done); end
      if (c == 4) begin
        total++;
        if (o_out_data !== 32'hA5A5_0001) begin
          bad++; $display("FAIL single_data got=%h want=a5a50001", o_out_data);
        end
        total++;
        if (o_out_last !== 1'b1) begin bad++; $display("FAIL single_last got=%b want=1", o_out_last); end
      end
      if (c == 2) begin
        total++;
        if (o_busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", o_busy); end
      end
      next_cycle();
    end
  endtask

  task automatic test_full_64();
    int beats = 0;
    begin_drain(6'd0, 32'h0, 64);
    for (int c = 0; c <= 262; c++) begin
      @(negedge clk);
      if (o_out_val) begin
        total++;
        if (o_out_data !== 32'(beats) || c != 4 * (beats + 1)) begin
          bad++; $display("FAIL full_beat c=%0d got=%h want=%h", c, o_out_data, 32'(beats));
        end
        total++;
        if (o_out_last !== (beats == 63)) begin
          bad++; $display("FAIL full_last beat=%0d got=%b", beats, o_out_last);
        end
        beats++;
      end
      total++;
      if (o_done !== (c == 257)) begin bad++; $display("FAIL full_done c=%0d got=%b", c, o_done); end
      next_cycle();
    end
    total++;
    if (beats != 64) begin bad++; $display("FAIL full_count got=%0d want=64", beats); end
    total++;
    if (o_err !== 1'b0) begin bad++; $display("FAIL full_err got=%b want=0", o_err); end
  endtask

  task automatic test_backpressure();
    int beats = 0;
    begin_drain(6'd3, 32'h1000_0000, 3);
    for (int c = 0; c <= 22; c++) begin
      @(negedge clk);
      if (o_out_val && i_out_rdy) begin
        total++;
        if (o_out_data !== 32'h1000_0000 + 32'(beats)) begin
          bad++; $display("FAIL bp_order beat=%0d got=%h", beats, o_out_data);
        end
        beats++;
      end
      if (c >= 8 && c <= 13) begin
        total++;
        if (o_out_val !== 1'b1 || o_out_data !== 32'h1000_0001) begin
          bad++; $display("FAIL bp_stall c=%0d val=%b got=%h want=10000001", c, o_out_val, o_out_data);
        end
        total++;
        if (o_buf_val_op !== 1'b0) begin bad++; $display("FAIL bp_vop c=%0d got=%b", c, o_buf_val_op); end
      end
      total++;
      if (o_done !== (c == 18)) begin bad++; $display("FAIL bp_done c=%0d got=%b", c, o_done); end
      next_cycle();
      i_out_rdy = !(c + 1 >= 8 && c + 1 <= 12);
    end
    total++;
    if (beats != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", beats); end
  endtask

  task automatic test_timeout();
    int beats = 0;
    begin_drain(6'd2, 32'h2000_0000, 1);
    for (int c = 0; c <= 26; c++) begin
      @(negedge clk);
      if (o_out_val) begin
        total++;
        if (o_out_data !== 32'h2000_0000) begin bad++; $display("FAIL to_data got=%h", o_out_data); end
        beats++;
      end
      total++;
      if (o_done !== (c == 20)) begin bad++; $display("FAIL to_done c=%0d got=%b", c, o_done); end
      total++;
      if (o_err !== (c >= 20)) begin bad++; $display("FAIL to_err c=%0d got=%b", c, o_err); end
      if (c == 21) begin
        total++;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL to_busy got=%b want=0", o_busy); end
      end
      next_cycle();
    end
    total++;
    if (beats != 1) begin bad++; $display("FAIL to_count got=%0d want=1", beats); end
  endtask

  task automatic test_start_while_busy();
    int beats = 0;
    begin_drain(6'd2, 32'h3000_0000, 2);
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total++;
        if (o_err !== 1'b1) begin bad++; $display("FAIL swb_err_sticky got=%b want=1", o_err); end
      end
      if (c == 1) begin
        total++;
        if (o_err !== 1'b0) begin bad++; $display("FAIL swb_err_clear got=%b want=0", o_err); end
      end
      if (o_out_val) beats++;
      total++;
      if (o_done !== (c == 9)) begin bad++; $display("FAIL swb_done c=%0d got=%b", c, o_done); end
      next_cycle();
      if (c + 1 == 2 || c + 1 == 6) begin i_start = 1'b1; i_len = 6'd5; end
    end
    total++;
    if (beats != 2) begin bad++; $display("FAIL swb_count got=%0d want=2", beats); end
  endtask

  task automatic test_reset_mid();
    begin_drain(6'd8, 32'h4000_0000, 8);
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      next_cycle();
      if (c + 1 == 11) reset = 1'b1;
    end
    reset = 1'b0;
    for (int c = 12; c <= 16; c++) begin
      @(negedge clk);
      total++;
      if ({o_busy, o_out_val, o_done, o_buf_val_op} !== 4'b0) begin
        bad++; $display("FAIL rst_mid c=%0d got=%b want=0000", c,
                        {o_busy, o_out_val, o_done, o_buf_val_op});
      end
      next_cycle();
    end
    begin_drain(6'd1, 32'h5555_AAAA, 1);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      total++;
      if (o_out_val !== (c == 4)) begin bad++; $display("FAIL rst_new_val c=%0d got=%b", c, o_out_val); end
      if (c == 4) begin
        total++;
        if (o_out_data !== 32'h5555_AAAA) begin bad++; $display("FAIL rst_new_data got=%h", o_out_data); end
      end
      total++;
      if (o_done !== (c == 5)) begin bad++; $display("FAIL rst_new_done c=%0d got=%b", c, o_done); end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_64();
    test_backpressure();
    test_timeout();
    test_start_while_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_buf_drain.md
# sipo_buf_drain

Read-out engine downstream of the 256-byte SIPO capture buffer. On a software start, it issues a programmed number of sequential read operations to the buffer over its op/ack/commit handshake. It captures each 32-bit word and presents it on a valid/ready stream toward the host read port, flagging the last word. A per-word watchdog aborts the transfer if the buffer stops responding.

## Interface
- DATA_W, 32, buffer word width
- WORDS, 64, buffer depth in words (256 B / 4 B)
- TIMEOUT, 15, max cycles from read request to commit before abort (4-bit counter)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin drain; sampled only in IDLE
- len  in  6  words to drain; 0 means 64
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse at transfer end (normal or abort)
- err  out  1  sticky timeout flag; cleared by next accepted start or reset
- buf_val_op  out  1  read request to buffer
- buf_op  out  1  constant 1 (read)
- buf_op_ack  in  1  buffer accepted request
- buf_op_commit  in  1  buffer read data valid this cycle
- buf_rdata  in  DATA_W  buffer read data
- out_val  out  1  stream data valid
- out_rdy  in  1  stream consumer ready
- out_data  out  DATA_W  captured word
- out_last  out  1  high with out_val on final word

## Operation
- States: IDLE, REQ, WAIT, OUT, DONE.
- IDLE: start=1 loads remaining count (len, 0→64) and clears err, then moves to REQ. start in any other state is ignored.
- REQ: buf_val_op=1 (registered, decoded from state). buf_op_ack=1 moves to WAIT. buf_val_op remains high in the ack cycle; the buffer ignores it there.
- WAIT: buf_op_commit=1 captures buf_rdata into out_data and moves to OUT. The remaining count is decremented at capture.
- OUT: out_val=1. If out_val&&out_rdy and remaining==0, move to DONE. If out_val&&out_rdy and remaining!=0, move to REQ. Otherwise hold; out_data stays stable while out_val is high.
- out_last = out_val && remaining==0.
- DONE: done=1 for one cycle, then IDLE.
- Watchdog:
  - 4-bit counter, cleared on entering REQ; counts each cycle in REQ or WAIT.
  - Reaching TIMEOUT before commit sets err=1 and moves to DONE. No word is output for the aborted request.
- Ack or commit arriving outside REQ/WAIT is ignored.
- Words are read in the buffer's internal address order; the drain does not drive an address.
- Remaining count is 7 bits; it never underflows.

## Timing
- Reset values: busy=0, done=0, err=0, buf_val_op=0, buf_op=1, out_val=0, out_last=0, out_data=0; state IDLE, counters 0.
- Per-word sequence, starting with start in cycle 0:
  - buf_val_op=1 in cycle 1.
  - buffer ack in cycle 2; WAIT in cycle 3 with commit.
  - out_val=1 in cycle 4.
- With out_rdy held high, one word per 4 cycles. Word k (1-based) has out_val in cycle 4k.
- done pulses in cycle 4N+1 for an N-word drain with no backpressure.
- Backpressure adds cycles only in OUT; the watchdog does not run in OUT.
- Reset mid-transfer: IDLE next cycle, no done pulse, err cleared, out_val dropped. The buffer shares the reset.
- start coinciding with reset: reset wins.

## Test plan
- len=1, out_rdy=1, buffer model acks 1 cycle after val_op and commits the next cycle with 0xA5A5_0001 → out_val in cycle 4 with out_data=0xA5A5_0001 and out_last=1; done in cycle 5; buf_val_op high only in cycles 1–2.
- len=0 (64 words), incrementing data 0..63, out_rdy=1 → 64 beats in order; out_last only on beat 64 (data 63); done in cycle 257; err=0.
- len=3, out_rdy low for 5 cycles on word 2 → word 2 data stable through the stall; no extra buf_val_op during the stall; all 3 words delivered; done 5 cycles later than the unstalled case.
- len=2, buffer never commits the second read → err=1 and done pulse TIMEOUT cycles after the second REQ entry; only word 1 output; err stays high until the next start.
- Reset asserted in WAIT of word 3 of 8 → next cycle busy=0, out_val=0, no done. A new start with len=1 then completes normally.
- start pulsed while busy → ignored: count unchanged and no extra words.
